display_scan_scheduler: RTL and testbench
=========================================

Name: display_scan_scheduler

Overview:
- Owns the 4-digit 7-segment display and decides which service's 16-bit BCD value is shown.
- Sources: current time, service 1 time-set, service 2 alarm-set, service 3 mini game, plus an alarm-ring override.
- Time-multiplexes the four digits (anode scan) and switches the shown source only at frame boundaries, so the display never tears.
- Generates cursor blink for the edit services and the colon/dp blink for time display.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); must be >= 2
BLINK_FRAMES, 125, frames per blink half-period (one frame = 4 digit slots)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous, active-low reset
svc_sel  input  4  service switches, one-hot; bit3=service1 .. bit0=service4
alarm_ring  input  1  alarm currently ringing
time_bcd  input  16  current time, 4 BCD nibbles, [15:12] = leftmost digit
set_bcd  input  16  service 1 edit value
alarm_bcd  input  16  service 2 alarm value
game_bcd  input  16  service 3 display value
cursor  input  4  digit under edit; cursor[3] = leftmost digit
seg  output  8  seg[6:0] = gfedcba, active-high; seg[7] = dp, active-high
anode  output  4  digit enables, active-low, anode[3] = leftmost digit
active_src  output  3  committed source: 0 TIME, 1 SET, 2 ALARM, 3 GAME, 4 RING

Behaviour:
- Reset (async, resetn=0), applied immediately at any point including mid-frame:
  - scan_cnt=0, digit_idx=0, frame_cnt=0, blink_phase=0 (visible).
  - frame_val=16'h0000, active_src=0.
  - anode=4'b1111, seg=8'h00.
- Scan:
  - scan_cnt counts 0..REFRESH_DIV-1 and wraps.
  - At the wrap, digit_idx advances 0->1->2->3->0.
  - Outputs are registered, one cycle after digit_idx/frame_val.
  - anode: idx0=4'b0111, idx1=4'b1011, idx2=4'b1101, idx3=4'b1110.
  - First drive is anode=4'b0111 on the first edge after reset release.
- Source decode, combinational candidate:
  - alarm_ring=1 -> RING.
  - Otherwise svc_sel 1000 -> SET, 0100 -> ALARM, 0010 -> GAME, 0001 -> TIME.
  - Any other svc_sel pattern (0000 or multi-hot) -> TIME.
  - RING and TIME display time_bcd.
- Frame commit, at the digit_idx 3->0 transition only:
  - active_src <= candidate.
  - frame_val <= selected 16-bit value.
  - Nothing is committed mid-frame.
  - The first frame after reset shows 0000.
- Blink:
  - frame_cnt increments at each commit.
  - At BLINK_FRAMES-1, frame_cnt wraps to 0 and blink_phase toggles.
  - If the committed active_src differs from the previous one, frame_cnt=0 and blink_phase=0 on that commit.
- Digit nibble = frame_val[15-4*idx -: 4].
- Segment encoding: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- Blanking (seg[6:0]=0), checked in priority order:
  - Nibble > 9.
  - RING and blink_phase=1 (all digits blank).
  - SET or ALARM, cursor[3-idx]=1, and blink_phase=1. cursor is sampled live, not latched.
- dp:
  - seg[7] = ~blink_phase on idx1 when active_src is TIME or RING.
  - 0 in every other case, including GAME, which never blinks.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2):
1. Reset: hold resetn=0 -> anode=1111, seg=00, active_src=0. Release -> anode steps 0111 (4 cycles), 1011, 1101, 1110, 0111; frame 1 shows 0000 with dp on idx1.
2. svc_sel=0001, time_bcd=16'h1234 -> from frame 2: idx0 seg=0000110, idx1 seg[6:0]=1011011, idx2 1001111, idx3 1100110. idx1 seg[7] is 1 for 2 frames, then 0 for 2 frames.
3. Switch svc_sel 0001->1000 while idx=1, set_bcd=16'h0959 -> active_src stays 0 through idx3, becomes 1 at the 3->0 transition; blink_phase=0 and frame_cnt=0 on that commit.
4. SET, cursor=4'b0010, set_bcd=16'h0959 -> idx2 alternates 1101101 / 0000000 every 2 frames; idx0, idx1, idx3 steady; seg[7]=0.
5. alarm_ring=1 with svc_sel=0010 -> next commit active_src=4. All digits show time_bcd for 2 frames, then blank for 2 frames, repeating. Drop alarm_ring -> next commit active_src=3, no blinking.
6. svc_sel=1100, time_bcd=16'h0A05 -> active_src=0; idx1 blanked (nibble A); idx3 = 1101101. Assert resetn=0 mid-slot -> anode=1111 the same instant.

Source files
------------

// File: rtl/display_scan_scheduler.sv
// Drives the 4-digit 7-segment display: anode scan, frame-aligned source switching,
// edit-cursor blink and time-colon (dp) blink.
module display_scan_scheduler #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  svc_sel,
  input  logic        alarm_ring,
  input  logic [15:0] time_bcd,
  input  logic [15:0] set_bcd,
  input  logic [15:0] alarm_bcd,
  input  logic [15:0] game_bcd,
  input  logic [3:0]  cursor,
  output logic [7:0]  seg,
  output logic [3:0]  anode,
  output logic [2:0]  active_src
);

  localparam int unsigned SC_W = $clog2(REFRESH_DIV);
  localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [2:0] SRC_TIME  = 3'd0;
  localparam logic [2:0] SRC_SET   = 3'd1;
  localparam logic [2:0] SRC_ALARM = 3'd2;
  localparam logic [2:0] SRC_GAME  = 3'd3;
  localparam logic [2:0] SRC_RING  = 3'd4;

  logic [SC_W-1:0] scan_cnt;
  logic [1:0]      digit_idx;
  logic [FC_W-1:0] frame_cnt;
  logic            blink_phase;
  logic [15:0]     frame_val;

  logic [2:0]  cand_src;
  logic [15:0] cand_val;
  logic        slot_wrap;
  logic        frame_commit;
  logic [3:0]  nibble;
  logic [6:0]  seg_pat;
  logic        blank;
  logic        dp;
  logic [7:0]  seg_d;
  logic [3:0]  anode_d;

  // Candidate source; anything other than a clean one-hot selection falls back to time
  always_comb begin
    cand_src = SRC_TIME;
    if (alarm_ring) begin
      cand_src = SRC_RING;
    end else begin
      case (svc_sel)
        4'b1000: cand_src = SRC_SET;
        4'b0100: cand_src = SRC_ALARM;
        4'b0010: cand_src = SRC_GAME;
        default: cand_src = SRC_TIME;
      endcase
    end
  end

  always_comb begin
    cand_val = time_bcd;
    case (cand_src)
      SRC_SET:   cand_val = set_bcd;
      SRC_ALARM: cand_val = alarm_bcd;
      SRC_GAME:  cand_val = game_bcd;
      default:   cand_val = time_bcd;
    endcase
  end

  assign slot_wrap    = (scan_cnt == SC_W'(REFRESH_DIV - 1));
  assign frame_commit = slot_wrap && (digit_idx == 2'd3);

  always_comb begin
    nibble = frame_val[15:12];
    case (digit_idx)
      2'd0: nibble = frame_val[15:12];
      2'd1: nibble = frame_val[11:8];
      2'd2: nibble = frame_val[7:4];
      2'd3: nibble = frame_val[3:0];
      default: nibble = frame_val[15:12];
    endcase
  end

  always_comb begin
    seg_pat = 7'h00;
    case (nibble)
      4'd0: seg_pat = 7'b0111111;
      4'd1: seg_pat = 7'b0000110;
      4'd2: seg_pat = 7'b1011011;
      4'd3: seg_pat = 7'b1001111;
      4'd4: seg_pat = 7'b1100110;
      4'd5: seg_pat = 7'b1101101;
      4'd6: seg_pat = 7'b1111101;
      4'd7: seg_pat = 7'b0000111;
      4'd8: seg_pat = 7'b1111111;
      4'd9: seg_pat = 7'b1101111;
      default: seg_pat = 7'h00;
    endcase
  end

  // Cursor is read live so the edited digit follows the user immediately
  always_comb begin
    blank = 1'b0;
    if (nibble > 4'd9) begin
      blank = 1'b1;
    end else if ((active_src == SRC_RING) && blink_phase) begin
      blank = 1'b1;
    end else if (((active_src == SRC_SET) || (active_src == SRC_ALARM)) &&
                 cursor[2'd3 - digit_idx] && blink_phase) begin
      blank = 1'b1;
    end
    dp      = (digit_idx == 2'd1) &&
              ((active_src == SRC_TIME) || (active_src == SRC_RING)) && !blink_phase;
    seg_d   = {dp, blank ? 7'h00 : seg_pat};
    anode_d = ~(4'b1000 >> digit_idx);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt    <= '0;
      digit_idx   <= 2'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_val   <= 16'h0000;
      active_src  <= SRC_TIME;
      seg         <= 8'h00;
      anode       <= 4'b1111;
    end else begin
      scan_cnt <= slot_wrap ? '0 : scan_cnt + SC_W'(1);
      if (slot_wrap) begin
        digit_idx <= digit_idx + 2'd1;
      end
      // Source and value change only between frames so a frame never mixes sources
      if (frame_commit) begin
        active_src <= cand_src;
        frame_val  <= cand_val;
        if (cand_src != active_src) begin
          frame_cnt   <= '0;
          blink_phase <= 1'b0;
        end else if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
      seg   <= seg_d;
      anode <= anode_d;
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: frame-level reference model compared every cycle,
// directed frames with hand-derived segment values, then randomized service traffic.
module tb_display_scan_scheduler;

  localparam int unsigned RD = 4;
  localparam int unsigned BF = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [3:0]  svc_sel = 4'b0001;
  logic        alarm_ring = 1'b0;
  logic [15:0] time_bcd = 16'h1234;
  logic [15:0] set_bcd = 16'h0959;
  logic [15:0] alarm_bcd = 16'h0730;
  logic [15:0] game_bcd = 16'h4321;
  logic [3:0]  cursor = 4'b0010;
  logic [7:0]  seg;
  logic [3:0]  anode;
  logic [2:0]  active_src;

  display_scan_scheduler #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetn(resetn), .svc_sel(svc_sel), .alarm_ring(alarm_ring),
    .time_bcd(time_bcd), .set_bcd(set_bcd), .alarm_bcd(alarm_bcd), .game_bcd(game_bcd),
    .cursor(cursor), .seg(seg), .anode(anode), .active_src(active_src)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;
  int cur_edge = 0;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model: cycle count since reset; frames of 4*RD cycles; blink phase from frames since source change
  int          n = 0;
  int          m_src = 0;
  int          since = 0;
  int          m_idx;
  int          m_c;
  logic [15:0] m_val = 16'h0000;
  logic [7:0]  e_seg = 8'h00;
  logic [3:0]  e_anode = 4'hF;
  logic [2:0]  e_src = 3'd0;

  function automatic int cand_src_f(logic ring, logic [3:0] sel);
    if (ring) return 4;
    if (sel == 4'b1000) return 1;
    if (sel == 4'b0100) return 2;
    if (sel == 4'b0010) return 3;
    return 0;
  endfunction

  function automatic logic [15:0] src_val_f(int src);
    if (src == 1) return set_bcd;
    if (src == 2) return alarm_bcd;
    if (src == 3) return game_bcd;
    return time_bcd;
  endfunction

  function automatic logic [7:0] digit_seg_f(int src, logic [15:0] val, int since_f,
                                             int idx, logic [3:0] cur);
    int         phase = (since_f / BF) % 2;
    logic [3:0] nib = 4'(val >> (4 * (3 - idx)));
    logic [6:0] pat = (nib <= 4'd9) ? seg_tbl[nib] : 7'h00;
    logic       dp_f;
    if (src == 4 && phase == 1) pat = 7'h00;
    if ((src == 1 || src == 2) && cur[3 - idx] && phase == 1) pat = 7'h00;
    dp_f = (idx == 1) && (src == 0 || src == 4) && (phase == 0);
    return {dp_f, pat};
  endfunction

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      n = 0; m_src = 0; since = 0; m_val = 16'h0000;
      e_seg = 8'h00; e_anode = 4'hF; e_src = 3'd0;
    end else begin
      m_idx   = (n / RD) % 4;
      e_anode = 4'(~(4'b1000 >> m_idx));
      e_seg   = digit_seg_f(m_src, m_val, since, m_idx, cursor);
      if ((n + 1) % (4 * RD) == 0) begin
        m_c   = cand_src_f(alarm_ring, svc_sel);
        since = (m_c == m_src) ? since + 1 : 0;
        m_src = m_c;
        m_val = src_val_f(m_c);
      end
      n++;
      e_src = 3'(m_src);
    end
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      vectors++;
      if ({seg, anode, active_src} !== {e_seg, e_anode, e_src}) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t: seg=%h anode=%b src=%0d, want seg=%h anode=%b src=%0d",
                 $time, seg, anode, active_src, e_seg, e_anode, e_src);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s edge=%0d: got %h, want %h", name, cur_edge, act, exp);
    end
  endtask

  task automatic to_edge(input int k);
    repeat (k - cur_edge) @(negedge clk);
    cur_edge = k;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(11));
    return v;
  endfunction

  task automatic random_cycles(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ($urandom_range(39) == 0)  svc_sel = 4'($urandom);
      if ($urandom_range(119) == 0) alarm_ring = ~alarm_ring;
      if ($urandom_range(29) == 0)  time_bcd = rand_bcd();
      if ($urandom_range(29) == 0)  set_bcd = rand_bcd();
      if ($urandom_range(29) == 0)  alarm_bcd = rand_bcd();
      if ($urandom_range(29) == 0)  game_bcd = rand_bcd();
      if ($urandom_range(7) == 0)   cursor = 4'($urandom);
    end
  endtask

  initial begin
    #1 resetn = 1'b0;
    armed = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_anode", 8'(anode), 8'h0F);
    chk("reset_seg", seg, 8'h00);
    chk("reset_src", 8'(active_src), 8'h00);
    resetn = 1'b1;
    cur_edge = 0;

    // Reset frame shows 0000 with dp on the second digit
    to_edge(1);  chk("anode_first", 8'(anode), 8'h07);
    to_edge(4);  chk("anode_hold", 8'(anode), 8'h07);
    to_edge(5);  chk("anode_idx1", 8'(anode), 8'h0B);
                 chk("frame1_dp", seg, 8'hBF);
    to_edge(9);  chk("anode_idx2", 8'(anode), 8'h0D);
    to_edge(13); chk("anode_idx3", 8'(anode), 8'h0E);
    to_edge(17); chk("anode_wrap", 8'(anode), 8'h07);
                 chk("time_d0", seg, 8'h06);
    to_edge(21); chk("time_d1_dp", seg, 8'hDB);
    to_edge(25); chk("time_d2", seg, 8'h4F);
    to_edge(29); chk("time_d3", seg, 8'h66);
    to_edge(37); chk("time_d1_nodp", seg, 8'h5B);

    // Switch to SET mid-frame: takes effect only at the frame boundary
    svc_sel = 4'b1000;
    to_edge(47); chk("src_hold", 8'(active_src), 8'h00);
    to_edge(48); chk("src_set", 8'(active_src), 8'h01);
    to_edge(49); chk("set_d0", seg, 8'h3F);
    to_edge(53); chk("set_d1", seg, 8'h6F);
    to_edge(57); chk("set_cursor_on", seg, 8'h6D);
    to_edge(85); chk("set_d1_steady", seg, 8'h6F);
    to_edge(89); chk("set_cursor_off", seg, 8'h00);

    alarm_ring = 1'b1; svc_sel = 4'b0010;
    to_edge(96);
    to_edge(112); chk("src_ring", 8'(active_src), 8'h04);
    to_edge(113); chk("ring_d0_on", seg, 8'h06);
    to_edge(117); chk("ring_d1_dp", seg, 8'hDB);
    to_edge(145); chk("ring_d0_off", seg, 8'h00);
    to_edge(149); chk("ring_d1_off", seg, 8'h00);

    // Multi-hot select falls back to time; nibble A blanks its digit
    to_edge(160);
    alarm_ring = 1'b0; svc_sel = 4'b1100; time_bcd = 16'h0A05;
    to_edge(176); chk("src_multihot", 8'(active_src), 8'h00);
    to_edge(177); chk("hex_d0", seg, 8'h3F);
    to_edge(181); chk("hex_blank_dp", seg, 8'h80);
    to_edge(189); chk("hex_d3", seg, 8'h6D);

    random_cycles(3000);

    // Asynchronous reset in the middle of a slot
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_anode", 8'(anode), 8'h0F);
    chk("async_seg", seg, 8'h00);
    chk("async_src", 8'(active_src), 8'h00);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    random_cycles(500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
